program_sequencer: RTL and testbench

- Upstream control stage for the single-cycle datapath top. It generates the 3-bit instruction address and the per-instruction RegWrite/MemWrite strobes that the datapath currently takes from switches.
- It steps through instruction memory either free-running or one instruction per debounced push-button press.
- It stops at a configured last address and reports busy, done and a retired-instruction count.

---
 rtl/program_sequencer.sv | 100 ++++++++++
 tb/tb_program_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: steps a 3-bit instruction address and per-instruction write strobes for the datapath
//   clk, rst            : system clock, synchronous active-high reset
//   start, run_mode     : begin a run from address 0; 1 = free-run, 0 = single-step
//   step_btn, halt      : raw bouncy step button; abort run back to IDLE
//   instruction_A       : instruction memory address
//   RegWrite, MemWrite  : write strobes, high only in EXEC per the masks
//   busy, done, retired : FETCH/EXEC/WAIT, DONE, EXEC cycles since last start
module program_sequencer #(
    parameter int ADDR_W = 3,
    parameter int LAST_ADDR = 7,
    parameter logic [2**ADDR_W-1:0] REG_WRITE_MASK = 8'b0000_1111,
    parameter logic [2**ADDR_W-1:0] MEM_WRITE_MASK = 8'b0011_0000,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              run_mode,
    input  logic              step_btn,
    input  logic              halt,
    output logic [ADDR_W-1:0] instruction_A,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   retired
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr_n, addr_inc;
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic level, settle, step_pulse, running;
    // settle marks the DEBOUNCE_CYCLES-th consecutive sample disagreeing with the debounced level
    assign settle = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign addr_inc = (instruction_A < LAST) ? instruction_A + 1'b1 : instruction_A;
    assign running = (state == FETCH) || (state == EXEC) || (state == WAIT);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            sync       <= {sync[0], step_btn};
            cnt        <= (sync[1] != level && !settle) ? cnt + 1'b1 : '0;
            level      <= settle ? sync[1] : level;
            step_pulse <= settle && sync[1];
        end
    end
    always_comb begin
        state_n = state;
        addr_n  = instruction_A;
        case (state)
            IDLE, DONE: if (start) begin
                state_n = FETCH;
                addr_n  = '0;
            end
            FETCH: state_n = EXEC;
            EXEC: if (instruction_A == LAST) state_n = DONE;
                  else if (run_mode) begin
                      state_n = FETCH;
                      addr_n  = addr_inc;
                  end else state_n = WAIT;
            WAIT: if (step_pulse || run_mode) begin
                state_n = FETCH;
                addr_n  = addr_inc;
            end
            default: state_n = IDLE;
        endcase
        // halt overrides any advance; an EXEC in progress still retires below
        if (halt && running) begin
            state_n = IDLE;
            addr_n  = '0;
        end
    end
    // outputs are registered from the next state so they stay Moore on the registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            instruction_A <= '0;
            RegWrite      <= 1'b0;
            MemWrite      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            retired       <= '0;
        end else begin
            state         <= state_n;
            instruction_A <= addr_n;
            RegWrite      <= (state_n == EXEC) && REG_WRITE_MASK[addr_n];
            MemWrite      <= (state_n == EXEC) && MEM_WRITE_MASK[addr_n];
            busy          <= state_n inside {FETCH, EXEC, WAIT};
            done          <= state_n == DONE;
            if ((state == IDLE || state == DONE) && start) retired <= '0;
            else if (state == EXEC) retired <= retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed checks of free-run, single-step, halt, reset and start handling
module tb_program_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, run_mode = 1'b1, step_btn = 1'b0, halt = 1'b0;
    logic [2:0] instruction_A;
    logic RegWrite, MemWrite, busy, done;
    logic [3:0] retired;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    program_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .run_mode(run_mode), .step_btn(step_btn),
        .halt(halt), .instruction_A(instruction_A), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .busy(busy), .done(done), .retired(retired)
    );
    function automatic logic [10:0] obs();
        return {instruction_A, RegWrite, MemWrite, busy, done, retired};
    endfunction
    function automatic logic [10:0] pk(int a, bit rw, bit mw, bit b, bit d, int r);
        logic [2:0] a3 = a[2:0];
        logic [3:0] r4 = r[3:0];
        return {a3, rw, mw, b, d, r4};
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic pairs(int a0, int a1, int r0, bit poke);
        for (int a = a0; a <= a1; a++) begin
            chk("fetch", obs(), pk(a, 0, 0, 1, 0, r0 + a - a0));
            if (poke && (a == 2 || a == 5)) start = 1'b1;
            tick();
            start = 1'b0;
            chk("exec", obs(), pk(a, a < 4, a == 4 || a == 5, 1, 0, r0 + a - a0));
            tick();
        end
    endtask
    task automatic btn(bit v, int n);
        step_btn = v;
        repeat (n) tick();
    endtask
    initial begin
        int adv, rw1;
        logic [2:0] prev;
        tick();
        rst = 1'b0;
        chk("reset", obs(), pk(0, 0, 0, 0, 0, 0));
        tick();
        chk("idle_hold", obs(), pk(0, 0, 0, 0, 0, 0));
        go();
        pairs(0, 7, 0, 0);
        chk("done1", obs(), pk(7, 0, 0, 0, 1, 8));
        tick();
        chk("done_hold", obs(), pk(7, 0, 0, 0, 1, 8));
        go();
        pairs(0, 7, 0, 1);
        chk("done_poke", obs(), pk(7, 0, 0, 0, 1, 8));
        go();
        pairs(0, 2, 0, 0);
        chk("fetch3", obs(), pk(3, 0, 0, 1, 0, 3));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt", obs(), pk(0, 0, 0, 0, 0, 3));
        tick();
        chk("halt_idle", obs(), pk(0, 0, 0, 0, 0, 3));
        go();
        pairs(0, 3, 0, 0);
        chk("fetch4", obs(), pk(4, 0, 0, 1, 0, 4));
        tick();
        chk("exec4", obs(), pk(4, 0, 1, 1, 0, 4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", obs(), pk(0, 0, 0, 0, 0, 0));
        go();
        pairs(0, 7, 0, 0);
        chk("done_after_rst", obs(), pk(7, 0, 0, 0, 1, 8));
        run_mode = 1'b0;
        go();
        chk("ss_fetch0", obs(), pk(0, 0, 0, 1, 0, 0));
        tick();
        chk("ss_exec0", obs(), pk(0, 1, 0, 1, 0, 0));
        tick();
        chk("ss_wait0", obs(), pk(0, 0, 0, 1, 0, 1));
        repeat (3) tick();
        chk("ss_wait0_hold", obs(), pk(0, 0, 0, 1, 0, 1));
        adv = 0;
        rw1 = 0;
        prev = instruction_A;
        for (int i = 0; i < 13; i++) begin
            step_btn = (i < 3) ? ~i[0] : 1'b1;
            tick();
            if (instruction_A != prev) adv++;
            if (RegWrite && instruction_A == 3'd1) rw1++;
            prev = instruction_A;
        end
        btn(1'b0, 10);
        chk("ss_advances", adv, 1);
        chk("ss_exec1", rw1, 1);
        chk("ss_wait1", obs(), pk(1, 0, 0, 1, 0, 2));
        btn(1'b1, 10);
        btn(1'b0, 10);
        chk("ss_wait2", obs(), pk(2, 0, 0, 1, 0, 3));
        run_mode = 1'b1;
        tick();
        pairs(3, 7, 3, 0);
        chk("done_mode", obs(), pk(7, 0, 0, 0, 1, 8));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
